// File: rtl/adex_neuron_array.sv
// adex_neuron_array: time-multiplexed AdEx neuron array sharing one fixed-point datapath and exp LUT.
// Each neuron takes two cycles per sweep: CALC latches the update, WB commits it.
module adex_neuron_array #(
    parameter int N_NEURONS   = 4,
    parameter int ID_W        = $clog2(N_NEURONS),
    parameter int W           = 16,
    parameter int LUT_ENTRIES = 32,
    parameter int V_REST      = 0,
    parameter int V_RESET     = -256,
    parameter int V_T         = 1024,
    parameter int V_PEAK      = 2048,
    parameter int LEAK_SHIFT  = 3,
    parameter int DELTA_SHIFT = 5,
    parameter int A_SHIFT     = 4,
    parameter int TAUW_SHIFT  = 3,
    parameter int B           = 64,
    parameter int REFRAC      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    input  logic                 i_wr_en,
    input  logic [ID_W-1:0]      i_wr_addr,
    input  logic [W-1:0]         i_wr_data,
    input  logic [ID_W-1:0]      probe_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 spike_valid,
    output logic [ID_W-1:0]      spike_id,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic [W-1:0]         probe_v,
    output logic                 overrun
);
    localparam int X  = W + 4;
    localparam int LW = $clog2(LUT_ENTRIES);
    localparam int RW = $clog2(REFRAC + 2);
    localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_WB = 2'd2;
    localparam logic signed [W-1:0] MAX_W    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_W    = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [X-1:0] MAX_X    = {{(X-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [X-1:0] MIN_X    = {{(X-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [X-1:0] VT_X     = X'(V_T);
    localparam logic signed [X-1:0] VREST_X  = X'(V_REST);
    localparam logic signed [X-1:0] B_X      = X'(B);
    localparam logic signed [X-1:0] LMAX_X   = X'(LUT_ENTRIES - 1);
    localparam logic signed [W-1:0] VREST_W  = W'(V_REST);
    localparam logic signed [W-1:0] VRESET_W = W'(V_RESET);
    localparam logic signed [W-1:0] VPEAK_W  = W'(V_PEAK);

    function automatic logic signed [W-1:0] sat(input logic signed [X-1:0] a);
        return a > MAX_X ? MAX_W : a < MIN_X ? MIN_W : a[W-1:0];
    endfunction

    function automatic logic [W-1:0] lut_val(input int k);
        longint m;
        if ((k >> 2) > W) return MAX_W;
        m = (longint'(4 + (k & 3)) << (k >> 2)) >> 2;
        return m > longint'(MAX_W) ? MAX_W : W'(m);
    endfunction

    logic [W-1:0] lut [LUT_ENTRIES];
    for (genvar k = 0; k < LUT_ENTRIES; k++) begin : g_lut
        assign lut[k] = lut_val(k);
    end

    logic signed [W-1:0]  v_q [N_NEURONS];
    logic signed [W-1:0]  w_q [N_NEURONS];
    logic signed [W-1:0]  i_q [N_NEURONS];
    logic [RW-1:0]        rf_q [N_NEURONS];
    logic [1:0]           state_q, state_d;
    logic [ID_W-1:0]      idx_q;
    logic signed [W-1:0]  vn_q, vn_d, wn_q, wn_d;
    logic [RW-1:0]        rfn_q, rfn_d;
    logic                 fire_q, fire_d;
    logic [N_NEURONS-1:0] flags_q, spike_vec_q;
    logic [W-1:0]         probe_q;
    logic                 overrun_q;
    logic                 last;

    logic signed [X-1:0] v_x, w_x, i_x, d_x, expt_x, vs_x, ws_x;
    logic signed [W-1:0] vsat, wsat;
    logic [LW-1:0]       li;
    logic [RW-1:0]       rf_cur;
    logic                refr;

    assign last = 32'(idx_q) == N_NEURONS - 1;

    always_comb state_d = state_q == S_IDLE ? (step ? S_CALC : S_IDLE)
                        : state_q == S_CALC ? S_WB : (last ? S_IDLE : S_CALC);

    // Datapath works at W+4 bits so the five-term sum cannot wrap before saturation.
    always_comb begin
        v_x    = X'(v_q[idx_q]);
        w_x    = X'(w_q[idx_q]);
        i_x    = X'(i_q[idx_q]);
        rf_cur = rf_q[idx_q];
        d_x    = (v_x - VT_X) >>> DELTA_SHIFT;
        li     = d_x > LMAX_X ? LW'(LUT_ENTRIES - 1) : d_x[LW-1:0];
        expt_x = v_x < VT_X ? '0 : {{(X-W){1'b0}}, lut[li]};
        vs_x   = v_x + ((VREST_X - v_x) >>> LEAK_SHIFT) + expt_x + i_x - w_x;
        ws_x   = w_x + ((v_x - VREST_X) >>> A_SHIFT) - (w_x >>> TAUW_SHIFT);
        vsat   = sat(vs_x);
        wsat   = sat(ws_x);
        refr   = rf_cur != '0;
        fire_d = !refr && vsat >= VPEAK_W;
        vn_d   = (refr || fire_d) ? VRESET_W : vsat;
        wn_d   = fire_d ? sat(X'(wsat) + B_X) : wsat;
        rfn_d  = refr ? rf_cur - 1'b1 : fire_d ? RW'(REFRAC) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            vn_q        <= '0;
            wn_q        <= '0;
            rfn_q       <= '0;
            fire_q      <= 1'b0;
            flags_q     <= '0;
            spike_vec_q <= '0;
            probe_q     <= VREST_W;
            overrun_q   <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                v_q[n]  <= VREST_W;
                w_q[n]  <= '0;
                i_q[n]  <= '0;
                rf_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            probe_q <= v_q[probe_sel];
            if (step && state_q != S_IDLE) overrun_q <= 1'b1;
            if (i_wr_en && 32'(i_wr_addr) < N_NEURONS) i_q[i_wr_addr] <= i_wr_data;
            if (state_q == S_IDLE && step) flags_q <= '0;
            if (state_q == S_CALC) begin
                vn_q   <= vn_d;
                wn_q   <= wn_d;
                rfn_q  <= rfn_d;
                fire_q <= fire_d;
            end
            if (state_q == S_WB) begin
                v_q[idx_q]     <= vn_q;
                w_q[idx_q]     <= wn_q;
                rf_q[idx_q]    <= rfn_q;
                flags_q[idx_q] <= fire_q;
                idx_q          <= last ? '0 : idx_q + 1'b1;
                if (last) spike_vec_q <= flags_q | (N_NEURONS'(fire_q) << idx_q);
            end
        end
    end

    assign busy        = state_q != S_IDLE;
    assign done        = state_q == S_WB && last;
    assign spike_valid = state_q == S_WB && fire_q;
    assign spike_id    = idx_q;
    assign spike_vec   = spike_vec_q;
    assign probe_v     = probe_q;
    assign overrun     = overrun_q;
endmodule
